// File: rtl/bus_arb_pkg.sv
// Shared state encodings and master indices for the 2-master bus arbiter.
package bus_arb_pkg;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        WS_IDLE = 2'd0,
        WS_ADDR = 2'd1,
        WS_DATA = 2'd2
    } ws_e;

    typedef enum logic {
        RS_IDLE = 1'b0,
        RS_ADDR = 1'b1
    } rs_e;

endpackage

// File: rtl/bus_arb_2m_rr_arb2.sv
// Two-way arbiter: gnt is the winning master index (0 = M0, 1 = M1).
// BUS_ARB_FIXED_PRIO_EN selects fixed M0-first priority instead of round robin.
module rr_arb2
    import bus_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic       gnt
);

`ifdef BUS_ARB_FIXED_PRIO_EN
    logic unused_c;

    assign gnt      = ~req[0];
    assign unused_c = ^{clk, rst, adv, req[1]};
`else
    logic last_q;
    logic last_d;

    // On contention the master not granted last wins; a lone requester always wins.
    always_comb begin
        gnt = (req == 2'b11) ? ~last_q : req[1];
    end

    always_comb begin
        last_d = last_q;
        if (adv) begin
            last_d = gnt;
        end
    end

    // Pointer resets to M1 so that M0 wins the first contended round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= M1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: rtl/bus_arb_2m.sv
// 2-master to 1-slave AW/W/B/AR/R arbiter; IDs tagged with the master bit, B/R routed by tag.
// BUS_ARB_FIXED_PRIO_EN: fixed M0 priority on AW and AR instead of round robin.
module bus_arb_2m
    import bus_arb_pkg::*;
#(
    parameter int unsigned ADDRW = 32,
    parameter int unsigned DATAW = 32,
    parameter int unsigned MIDW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    // master 0
    input  logic                 m0_awvalid,
    output logic                 m0_awready,
    input  logic [MIDW-1:0]      m0_awid,
    input  logic [ADDRW-1:0]     m0_awaddr,
    input  logic [5:0]           m0_awatop,
    input  logic                 m0_wvalid,
    output logic                 m0_wready,
    input  logic [DATAW-1:0]     m0_wdata,
    input  logic [DATAW/8-1:0]   m0_wstrb,
    input  logic                 m0_wlast,
    output logic                 m0_bvalid,
    input  logic                 m0_bready,
    output logic [MIDW-1:0]      m0_bid,
    output logic                 m0_bcomp,
    input  logic                 m0_arvalid,
    output logic                 m0_arready,
    input  logic [MIDW-1:0]      m0_arid,
    input  logic [ADDRW-1:0]     m0_araddr,
    output logic                 m0_rvalid,
    input  logic                 m0_rready,
    output logic [MIDW-1:0]      m0_rid,
    output logic [DATAW-1:0]     m0_rdata,
    output logic                 m0_rlast,
    // master 1
    input  logic                 m1_awvalid,
    output logic                 m1_awready,
    input  logic [MIDW-1:0]      m1_awid,
    input  logic [ADDRW-1:0]     m1_awaddr,
    input  logic [5:0]           m1_awatop,
    input  logic                 m1_wvalid,
    output logic                 m1_wready,
    input  logic [DATAW-1:0]     m1_wdata,
    input  logic [DATAW/8-1:0]   m1_wstrb,
    input  logic                 m1_wlast,
    output logic                 m1_bvalid,
    input  logic                 m1_bready,
    output logic [MIDW-1:0]      m1_bid,
    output logic                 m1_bcomp,
    input  logic                 m1_arvalid,
    output logic                 m1_arready,
    input  logic [MIDW-1:0]      m1_arid,
    input  logic [ADDRW-1:0]     m1_araddr,
    output logic                 m1_rvalid,
    input  logic                 m1_rready,
    output logic [MIDW-1:0]      m1_rid,
    output logic [DATAW-1:0]     m1_rdata,
    output logic                 m1_rlast,
    // slave
    output logic                 s_awvalid,
    input  logic                 s_awready,
    output logic [MIDW:0]        s_awid,
    output logic [ADDRW-1:0]     s_awaddr,
    output logic [5:0]           s_awatop,
    output logic                 s_wvalid,
    input  logic                 s_wready,
    output logic [DATAW-1:0]     s_wdata,
    output logic [DATAW/8-1:0]   s_wstrb,
    output logic                 s_wlast,
    input  logic                 s_bvalid,
    output logic                 s_bready,
    input  logic [MIDW:0]        s_bid,
    input  logic                 s_bcomp,
    output logic                 s_arvalid,
    input  logic                 s_arready,
    output logic [MIDW:0]        s_arid,
    output logic [ADDRW-1:0]     s_araddr,
    input  logic                 s_rvalid,
    output logic                 s_rready,
    input  logic [MIDW:0]        s_rid,
    input  logic [DATAW-1:0]     s_rdata,
    input  logic                 s_rlast
);

    ws_e  ws_q, ws_d;
    rs_e  rs_q, rs_d;
    logic wg_q, wg_d;
    logic rg_q, rg_d;
    logic aw_adv, ar_adv;
    logic aw_gnt, ar_gnt;
    logic aw_v, w_v, w_last, ar_v;

    rr_arb2 u_aw_arb (
        .clk (clk),
        .rst (rst),
        .req ({m1_awvalid, m0_awvalid}),
        .adv (aw_adv),
        .gnt (aw_gnt)
    );

    rr_arb2 u_ar_arb (
        .clk (clk),
        .rst (rst),
        .req ({m1_arvalid, m0_arvalid}),
        .adv (ar_adv),
        .gnt (ar_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ws_q <= WS_IDLE;
            rs_q <= RS_IDLE;
            wg_q <= M0;
            rg_q <= M0;
        end else begin
            ws_q <= ws_d;
            rs_q <= rs_d;
            wg_q <= wg_d;
            rg_q <= rg_d;
        end
    end

    // Write path: payload muxed by the held grant, handshakes gated by state.
    always_comb begin
        ws_d       = ws_q;
        wg_d       = wg_q;
        aw_adv     = 1'b0;
        aw_v       = wg_q ? m1_awvalid : m0_awvalid;
        w_v        = wg_q ? m1_wvalid  : m0_wvalid;
        w_last     = wg_q ? m1_wlast   : m0_wlast;
        s_awvalid  = 1'b0;
        s_awid     = {wg_q, (wg_q ? m1_awid : m0_awid)};
        s_awaddr   = wg_q ? m1_awaddr : m0_awaddr;
        s_awatop   = wg_q ? m1_awatop : m0_awatop;
        s_wvalid   = 1'b0;
        s_wdata    = wg_q ? m1_wdata : m0_wdata;
        s_wstrb    = wg_q ? m1_wstrb : m0_wstrb;
        s_wlast    = w_last;
        m0_awready = 1'b0;
        m1_awready = 1'b0;
        m0_wready  = 1'b0;
        m1_wready  = 1'b0;
        case (ws_q)
            WS_IDLE: begin
                if (m0_awvalid || m1_awvalid) begin
                    wg_d   = aw_gnt;
                    aw_adv = 1'b1;
                    ws_d   = WS_ADDR;
                end
            end
            WS_ADDR: begin
                s_awvalid  = aw_v;
                m0_awready = (wg_q == M0) && s_awready;
                m1_awready = (wg_q == M1) && s_awready;
                if (aw_v && s_awready) begin
                    ws_d = WS_DATA;
                end
            end
            WS_DATA: begin
                s_wvalid  = w_v;
                m0_wready = (wg_q == M0) && s_wready;
                m1_wready = (wg_q == M1) && s_wready;
                if (w_v && s_wready && w_last) begin
                    ws_d = WS_IDLE;
                end
            end
            default: ws_d = WS_IDLE;
        endcase
    end

    // Read address path; no tracking of outstanding reads is needed.
    always_comb begin
        rs_d       = rs_q;
        rg_d       = rg_q;
        ar_adv     = 1'b0;
        ar_v       = rg_q ? m1_arvalid : m0_arvalid;
        s_arvalid  = 1'b0;
        s_arid     = {rg_q, (rg_q ? m1_arid : m0_arid)};
        s_araddr   = rg_q ? m1_araddr : m0_araddr;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        case (rs_q)
            RS_IDLE: begin
                if (m0_arvalid || m1_arvalid) begin
                    rg_d   = ar_gnt;
                    ar_adv = 1'b1;
                    rs_d   = RS_ADDR;
                end
            end
            RS_ADDR: begin
                s_arvalid  = ar_v;
                m0_arready = (rg_q == M0) && s_arready;
                m1_arready = (rg_q == M1) && s_arready;
                if (ar_v && s_arready) begin
                    rs_d = RS_IDLE;
                end
            end
            default: rs_d = RS_IDLE;
        endcase
    end

    // Responses are steered purely by the master tag in the top ID bit.
    always_comb begin
        m0_bvalid = s_bvalid && (s_bid[MIDW] == M0);
        m1_bvalid = s_bvalid && (s_bid[MIDW] == M1);
        m0_bid    = s_bid[MIDW-1:0];
        m1_bid    = s_bid[MIDW-1:0];
        m0_bcomp  = s_bcomp;
        m1_bcomp  = s_bcomp;
        s_bready  = s_bid[MIDW] ? m1_bready : m0_bready;

        m0_rvalid = s_rvalid && (s_rid[MIDW] == M0);
        m1_rvalid = s_rvalid && (s_rid[MIDW] == M1);
        m0_rid    = s_rid[MIDW-1:0];
        m1_rid    = s_rid[MIDW-1:0];
        m0_rdata  = s_rdata;
        m1_rdata  = s_rdata;
        m0_rlast  = s_rlast;
        m1_rlast  = s_rlast;
        s_rready  = s_rid[MIDW] ? m1_rready : m0_rready;
    end

endmodule

// File: tb/tb_bus_arb_2m.sv
// Directed self-checking bench for bus_arb_2m; honours BUS_ARB_FIXED_PRIO_EN when defined.
module tb_bus_arb_2m;

    localparam int unsigned ADDRW = 32;
    localparam int unsigned DATAW = 32;
    localparam int unsigned MIDW  = 3;

    logic clk = 1'b0;
    logic rst;

    logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_wlast, m0_bvalid, m0_bready, m0_bcomp;
    logic m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
    logic [MIDW-1:0] m0_awid, m0_bid, m0_arid, m0_rid;
    logic [ADDRW-1:0] m0_awaddr, m0_araddr;
    logic [5:0] m0_awatop;
    logic [DATAW-1:0] m0_wdata, m0_rdata;
    logic [DATAW/8-1:0] m0_wstrb;

    logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready, m1_bcomp;
    logic m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
    logic [MIDW-1:0] m1_awid, m1_bid, m1_arid, m1_rid;
    logic [ADDRW-1:0] m1_awaddr, m1_araddr;
    logic [5:0] m1_awatop;
    logic [DATAW-1:0] m1_wdata, m1_rdata;
    logic [DATAW/8-1:0] m1_wstrb;

    logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready, s_bcomp;
    logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [MIDW:0] s_awid, s_bid, s_arid, s_rid;
    logic [ADDRW-1:0] s_awaddr, s_araddr;
    logic [5:0] s_awatop;
    logic [DATAW-1:0] s_wdata, s_rdata;
    logic [DATAW/8-1:0] s_wstrb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arb_2m #(.ADDRW(ADDRW), .DATAW(DATAW), .MIDW(MIDW)) dut (
        .clk(clk), .rst(rst),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awid(m0_awid), .m0_awaddr(m0_awaddr),
        .m0_awatop(m0_awatop), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m0_bid(m0_bid), .m0_bcomp(m0_bcomp), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awid(m1_awid), .m1_awaddr(m1_awaddr),
        .m1_awatop(m1_awatop), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .m1_bid(m1_bid), .m1_bcomp(m1_bcomp), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
        .s_awatop(s_awatop), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_bid(s_bid), .s_bcomp(s_bcomp), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rlast(s_rlast)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One write burst granted to master g; both masters keep awvalid and wvalid high.
    task automatic wr_burst(input logic g, input int nb);
        tick();
        check("burst_awvalid", 64'(s_awvalid), 64'd1);
        check("burst_awgrant", 64'(s_awid[MIDW]), 64'(g));
        check("burst_awaddr", 64'(s_awaddr), g ? 64'h2000 : 64'h1000);
        check("burst_loser_awready", 64'(g ? m0_awready : m1_awready), 64'd0);
        tick();
        for (int i = 0; i < nb; i++) begin
            m0_wdata = 32'h1111_0000 + 32'(i);
            m1_wdata = 32'h2222_0000 + 32'(i);
            m0_wvalid = 1'b1;
            m1_wvalid = 1'b1;
            m0_wlast  = (i == nb - 1);
            m1_wlast  = (i == nb - 1);
            #1;
            check("burst_wvalid", 64'(s_wvalid), 64'd1);
            check("burst_wdata", 64'(s_wdata), g ? 64'(32'h2222_0000 + 32'(i)) : 64'(32'h1111_0000 + 32'(i)));
            check("burst_win_wready", 64'(g ? m1_wready : m0_wready), 64'd1);
            check("burst_lose_wready", 64'(g ? m0_wready : m1_wready), 64'd0);
            tick();
        end
        m0_wvalid = 1'b0;
        m1_wvalid = 1'b0;
        m0_wlast  = 1'b0;
        m1_wlast  = 1'b0;
    endtask

    initial begin
        logic g_exp;
        rst = 1'b1;
        {m0_awvalid, m0_wvalid, m0_wlast, m0_bready, m0_arvalid, m0_rready} = '0;
        {m1_awvalid, m1_wvalid, m1_wlast, m1_bready, m1_arvalid, m1_rready} = '0;
        m0_awid = '0; m0_awaddr = '0; m0_awatop = '0; m0_wdata = '0; m0_wstrb = '1; m0_arid = '0; m0_araddr = '0;
        m1_awid = '0; m1_awaddr = '0; m1_awatop = '0; m1_wdata = '0; m1_wstrb = '1; m1_arid = '0; m1_araddr = '0;
        {s_awready, s_wready, s_bvalid, s_bcomp, s_arready, s_rvalid, s_rlast} = '0;
        s_bid = '0; s_rid = '0; s_rdata = '0;

        // reset state
        tick();
        check("rst_s_awvalid", 64'(s_awvalid), 64'd0);
        check("rst_s_wvalid", 64'(s_wvalid), 64'd0);
        check("rst_s_arvalid", 64'(s_arvalid), 64'd0);
        check("rst_m_ready", 64'({m0_awready, m1_awready, m0_wready, m1_wready, m0_arready, m1_arready}), 64'd0);
        rst = 1'b0;

        // single M0 write
        s_awready = 1'b1; s_wready = 1'b1;
        m0_awvalid = 1'b1; m0_awid = 3'd3; m0_awaddr = 32'h100; m0_awatop = 6'h21;
        m0_wvalid = 1'b1; m0_wdata = 32'hDEADBEEF; m0_wlast = 1'b1;
        #1;
        check("w1_idle_awvalid", 64'(s_awvalid), 64'd0);
        check("w1_idle_wblocked", 64'({s_wvalid, m0_wready}), 64'd0);
        tick();
        check("w1_awvalid", 64'(s_awvalid), 64'd1);
        check("w1_awid", 64'(s_awid), 64'b0011);
        check("w1_awaddr", 64'(s_awaddr), 64'h100);
        check("w1_awatop", 64'(s_awatop), 64'h21);
        check("w1_awready", 64'(m0_awready), 64'd1);
        check("w1_w_before_aw", 64'(s_wvalid), 64'd0);
        tick();
        m0_awvalid = 1'b0;
        #1;
        check("w1_wvalid", 64'(s_wvalid), 64'd1);
        check("w1_wdata", 64'(s_wdata), 64'hDEADBEEF);
        check("w1_wlast_wstrb", 64'({s_wlast, s_wstrb}), 64'h1F);
        check("w1_wready", 64'({m0_wready, m1_wready}), 64'b10);
        tick();
        m0_wvalid = 1'b0; m0_wlast = 1'b0;
        check("w1_back_idle", 64'({s_awvalid, s_wvalid}), 64'd0);

        // B routing both ways
        s_bvalid = 1'b1; s_bid = 4'b0011; s_bcomp = 1'b1; m0_bready = 1'b1; m1_bready = 1'b0;
        #1;
        check("b_m0", 64'({m0_bvalid, m0_bid, m0_bcomp, m1_bvalid, s_bready}), 64'b1_011_1_0_1);
        s_bid = 4'b1100; s_bcomp = 1'b0;
        #1;
        check("b_m1", 64'({m1_bvalid, m1_bid, m1_bcomp, m0_bvalid, s_bready}), 64'b1_100_0_0_0);
        s_bvalid = 1'b0; m0_bready = 1'b0;

        // contended write bursts from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_awvalid = 1'b1; m0_awaddr = 32'h1000; m0_awid = 3'd1;
        m1_awvalid = 1'b1; m1_awaddr = 32'h2000; m1_awid = 3'd6;
        wr_burst(1'b0, 4);
`ifdef BUS_ARB_FIXED_PRIO_EN
        wr_burst(1'b0, 1);
`else
        wr_burst(1'b1, 1);
`endif
        wr_burst(1'b0, 2);
        m0_awvalid = 1'b0; m1_awvalid = 1'b0;
        tick();
        tick();

        // back-to-back reads and tagged R return
        s_arready = 1'b1;
        m0_arvalid = 1'b1; m0_arid = 3'd2; m0_araddr = 32'h200;
        tick();
        check("r1_arvalid", 64'(s_arvalid), 64'd1);
        check("r1_arid", 64'(s_arid), 64'b0010);
        check("r1_arready", 64'({m0_arready, m1_arready}), 64'b10);
        m1_arvalid = 1'b1; m1_arid = 3'd5; m1_araddr = 32'h280;
        tick();
        m0_arvalid = 1'b0;
        #1;
        check("r1_idle_gap", 64'(s_arvalid), 64'd0);
        tick();
        check("r2_arid", 64'(s_arid), 64'b1101);
        check("r2_araddr", 64'(s_araddr), 64'h280);
        check("r2_arready", 64'({m0_arready, m1_arready}), 64'b01);
        tick();
        m1_arvalid = 1'b0;
        s_rvalid = 1'b1; s_rid = 4'b1101; s_rdata = 32'h5555_AAAA; s_rlast = 1'b1;
        m0_rready = 1'b1; m1_rready = 1'b1;
        #1;
        check("rr_m1", 64'({m1_rvalid, m1_rid, m0_rvalid, s_rready, m1_rlast}), 64'b1_101_0_1_1);
        check("rr_m1_data", 64'(m1_rdata), 64'h5555_AAAA);
        s_rid = 4'b0010; s_rdata = 32'h1234_5678; m0_rready = 1'b0;
        #1;
        check("rr_m0", 64'({m0_rvalid, m0_rid, m1_rvalid, s_rready}), 64'b1_010_0_0);
        check("rr_m0_data", 64'(m0_rdata), 64'h1234_5678);
        s_rvalid = 1'b0; s_rlast = 1'b0;

        // AR stalled by the slave with both masters requesting
        s_arready = 1'b0;
        m0_arvalid = 1'b1; m0_arid = 3'd1; m0_araddr = 32'h300;
        m1_arvalid = 1'b1; m1_arid = 3'd6; m1_araddr = 32'h400;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_ar", 64'({s_arvalid, s_arid, s_araddr}), 64'({1'b1, 4'b0001, 32'h300}));
            check("stall_ready", 64'({m0_arready, m1_arready}), 64'd0);
            tick();
        end
        s_arready = 1'b1;
        #1;
        check("stall_release", 64'({m0_arready, m1_arready}), 64'b10);
        tick();
        m0_arvalid = 1'b0;
        tick();
        check("stall_next_arid", 64'(s_arid), 64'b1110);
        tick();
        m1_arvalid = 1'b0;

        // continuous AR contention, 4 reads
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
            g_exp = 1'b0;
`else
            g_exp = 1'(i % 2);
`endif
            tick();
            check("ar_contend_grant", 64'({s_arvalid, s_arid[MIDW]}), 64'({1'b1, g_exp}));
            tick();
        end
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        tick();

        // reset pulsed on beat 2 of an M1 burst
        m1_awvalid = 1'b1; m1_awaddr = 32'h500;
        tick();
        check("mid_awgrant", 64'(s_awid[MIDW]), 64'd1);
        tick();
        m1_awvalid = 1'b0; m1_wvalid = 1'b1; m1_wlast = 1'b0; m1_wdata = 32'hAAAA_0001;
        #1;
        check("mid_beat1", 64'({s_wvalid, m1_wready}), 64'b11);
        tick();
        m1_wdata = 32'hAAAA_0002;
        rst = 1'b1;
        #1;
        check("mid_rst_out", 64'({s_awvalid, s_wvalid, s_arvalid, m0_awready, m1_awready, m0_wready, m1_wready}), 64'd0);
        tick();
        check("mid_rst_edge", 64'({s_wvalid, m1_wready}), 64'd0);
        rst = 1'b0; m1_wvalid = 1'b0;
        m0_awvalid = 1'b1; m0_awaddr = 32'h600; m1_awvalid = 1'b1;
        tick();
        check("post_rst_grant", 64'({s_awvalid, s_awid[MIDW], m0_awready, m1_awready}), 64'b1_0_1_0);
        m0_awvalid = 1'b0; m1_awvalid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
